// File: rtl/ber_pkg.sv
// Shared definitions for the BER alignment/counting block: FSM encoding and
// width helpers for the default configuration.
package ber_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int BUFFER_DEF    = 16;
    localparam int ALIGN_LEN_DEF = 64;
    localparam int CNT_W_DEF     = 32;

    localparam int DW    = $clog2(BUFFER_DEF);
    localparam int WIN_W = $clog2(ALIGN_LEN_DEF + 1);
    localparam logic [CNT_W_DEF-1:0] CNT_SAT = {CNT_W_DEF{1'b1}};

    // Window error counters must hold the value ALIGN_LEN itself.
    function automatic int win_width(input int align_len);
        return $clog2(align_len + 1);
    endfunction

endpackage

// File: rtl/prbs_delay_line.sv
// Reference-bit delay line: shifts on enabled valid symbols, tap 0 is the
// current input, tap k is the bit from k valid symbols earlier.
module prbs_delay_line #(
    parameter int BUFFER = 16,
    parameter int DW     = $clog2(BUFFER)
) (
    input  logic          clock,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic          i_valid,
    input  logic          i_prbs,
    input  logic [DW-1:0] i_delay,
    output logic          o_tap
);

    logic [BUFFER-2:0] line;
    logic [BUFFER-1:0] taps;

    assign taps  = {line, i_prbs};
    assign o_tap = taps[i_delay];

    always_ff @(posedge clock) begin
        if (i_reset) begin
            line <= '0;
        end else if (i_enable && i_valid) begin
            line <= taps[BUFFER-2:0];
        end
    end

endmodule

// File: rtl/ber_counter.sv
// Delay search and locked BER accumulation: finds the reference delay with the
// fewest errors, locks to it, then counts errors and symbols with saturation.
module ber_counter #(
    parameter int BUFFER    = 16,
    parameter int ALIGN_LEN = 64,
    parameter int CNT_W     = 32,
    parameter int DW        = $clog2(BUFFER)
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_prbs,
    input  logic             i_slicer,
    input  logic             i_restart,
    output logic [DW-1:0]    o_delay,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_ber
);
    import ber_pkg::*;

    localparam int WW = win_width(ALIGN_LEN);
    localparam int SW = $clog2((ALIGN_LEN > BUFFER) ? ALIGN_LEN : BUFFER);
    localparam logic [CNT_W-1:0] SAT       = {CNT_W{1'b1}};
    localparam logic [SW-1:0]    FILL_LAST = SW'(BUFFER - 2);
    localparam logic [SW-1:0]    WIN_LAST  = SW'(ALIGN_LEN - 1);
    localparam logic [DW-1:0]    CAND_LAST = DW'(BUFFER - 1);

    state_t        state;
    logic [SW-1:0] sym_cnt;
    logic [WW-1:0] win_err;
    logic [WW-1:0] min_err;
    logic [WW-1:0] win_tot;
    logic [DW-1:0] best;
    logic [DW-1:0] final_delay;
    logic          tap;
    logic          err_bit;
    logic          better;

    prbs_delay_line #(
        .BUFFER (BUFFER),
        .DW     (DW)
    ) u_delay_line (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_valid  (i_valid),
        .i_prbs   (i_prbs),
        .i_delay  (o_delay),
        .o_tap    (tap)
    );

    // Error uses the pre-shift tap; window total includes the current symbol.
    assign err_bit     = i_slicer ^ tap;
    assign win_tot     = win_err + WW'(err_bit);
    assign better      = (win_tot < min_err) || (o_delay == '0);
    assign final_delay = better ? o_delay : best;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state     <= FILL;
            sym_cnt   <= '0;
            win_err   <= '0;
            min_err   <= '0;
            best      <= '0;
            o_delay   <= '0;
            o_locked  <= 1'b0;
            o_err_cnt <= '0;
            o_bit_cnt <= '0;
            o_ber     <= 1'b0;
        end else if (i_enable) begin
            if (i_restart) begin
                state     <= SEARCH;
                sym_cnt   <= '0;
                win_err   <= '0;
                min_err   <= '0;
                best      <= '0;
                o_delay   <= '0;
                o_locked  <= 1'b0;
                o_err_cnt <= '0;
                o_bit_cnt <= '0;
                o_ber     <= 1'b0;
            end else if (i_valid) begin
                case (state)
                    FILL: begin
                        if (sym_cnt == FILL_LAST) begin
                            state   <= SEARCH;
                            sym_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                    SEARCH: begin
                        if (sym_cnt != WIN_LAST) begin
                            sym_cnt <= sym_cnt + 1'b1;
                            win_err <= win_tot;
                        end else begin
                            sym_cnt <= '0;
                            win_err <= '0;
                            if (better) begin
                                min_err <= win_tot;
                                best    <= o_delay;
                            end
                            if (win_tot == '0 || o_delay == CAND_LAST) begin
                                state     <= LOCKED;
                                o_locked  <= 1'b1;
                                o_err_cnt <= '0;
                                o_bit_cnt <= '0;
                                o_ber     <= 1'b0;
                                if (win_tot != '0) begin
                                    o_delay <= final_delay;
                                end
                            end else begin
                                o_delay <= o_delay + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        o_ber <= err_bit;
                        if (o_bit_cnt != SAT) begin
                            o_bit_cnt <= o_bit_cnt + 1'b1;
                            o_err_cnt <= o_err_cnt + CNT_W'(err_bit);
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ber_counter.sv
// Scenario bench for ber_counter: PRBS9 source with a programmable reference
// delay and error injection, plus a narrow-counter instance for saturation.
module tb_ber_counter;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid;
    logic        i_prbs;
    logic        i_slicer;
    logic        i_restart;
    logic [3:0]  o_delay;
    logic        o_locked;
    logic [31:0] o_err_cnt;
    logic [31:0] o_bit_cnt;
    logic        o_ber;
    logic [3:0]  d8_delay;
    logic        d8_locked;
    logic [7:0]  d8_err_cnt;
    logic [7:0]  d8_bit_cnt;
    logic        d8_ber;

    ber_counter #(.BUFFER(16), .ALIGN_LEN(64), .CNT_W(32)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_prbs(i_prbs), .i_slicer(i_slicer), .i_restart(i_restart),
        .o_delay(o_delay), .o_locked(o_locked), .o_err_cnt(o_err_cnt),
        .o_bit_cnt(o_bit_cnt), .o_ber(o_ber)
    );

    ber_counter #(.BUFFER(16), .ALIGN_LEN(64), .CNT_W(8)) dut8 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_prbs(i_prbs), .i_slicer(i_slicer), .i_restart(i_restart),
        .o_delay(d8_delay), .o_locked(d8_locked), .o_err_cnt(d8_err_cnt),
        .o_bit_cnt(d8_bit_cnt), .o_ber(d8_ber)
    );

    always #5 clock = ~clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] lfsr    = 9'h1FF;
    logic [15:0] hist   = '0;
    int         inv_ctr = 0;
    bit         chk_ber = 1'b0;
    bit         last_exp = 1'b0;
    bit         exp_ber_q[$];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One valid symbol: reference from PRBS9, slicer = reference delayed by dly, optionally inverted.
    task automatic sym(input int dly, input bit inv);
        logic p;
        bit   e;
        p = lfsr[8] ^ lfsr[4];
        lfsr = {lfsr[7:0], p};
        i_valid  = 1'b1;
        i_prbs   = p;
        i_slicer = ((dly == 0) ? p : hist[dly-1]) ^ inv;
        hist = {hist[14:0], p};
        if (chk_ber) begin
            exp_ber_q.push_back(inv);
            last_exp = inv;
        end
        tick();
        i_valid   = 1'b0;
        i_restart = 1'b0;
        if (chk_ber) begin
            e = exp_ber_q.pop_front();
            n_tests++;
            if (o_ber !== e) begin
                n_fail++;
                $display("FAIL ber_pulse: o_ber=%0b expected %0b", o_ber, e);
            end
        end
    endtask

    task automatic idle;
        i_valid  = 1'b0;
        i_prbs   = 1'($urandom);
        i_slicer = 1'($urandom);
        tick();
    endtask

    task automatic run_to_lock(input int dly, input int period, input int max_sym,
                               input bit half_valid, output int n);
        n = 0;
        while (!o_locked && n < max_sym) begin
            if (half_valid) idle();
            sym(dly, (period != 0) && ((inv_ctr % period) == period - 1));
            inv_ctr++;
            n++;
        end
    endtask

    task automatic do_reset;
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        inv_ctr = 0;
    endtask

    task automatic test_reset;
        i_enable = 1'b1; i_valid = 1'b1; i_restart = 1'b1; i_prbs = 1'b1; i_slicer = 1'b0;
        i_reset = 1'b1;
        tick(); tick();
        i_reset = 1'b0; i_restart = 1'b0; i_valid = 1'b0;
        n_tests++; if (o_delay !== 4'd0) begin n_fail++; $display("FAIL reset_delay: got %0d expected 0", o_delay); end
        n_tests++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", o_locked); end
        n_tests++; if (o_err_cnt !== 32'd0 || o_bit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counts: err=%0d bit=%0d expected 0/0", o_err_cnt, o_bit_cnt); end
        n_tests++; if (o_ber !== 1'b0) begin n_fail++; $display("FAIL reset_ber: got %0b expected 0", o_ber); end
        n_tests++; if (d8_locked !== 1'b0 || d8_bit_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_dut8: locked=%0b bit=%0d expected 0/0", d8_locked, d8_bit_cnt); end
        // First FILL symbol leaves the delay output at 0.
        sym(5, 1'b0);
        inv_ctr++;
        n_tests++; if (o_delay !== 4'd0 || o_locked !== 1'b0) begin n_fail++; $display("FAIL fill_outputs: delay=%0d locked=%0b expected 0/0", o_delay, o_locked); end
        do_reset();
    endtask

    task automatic test_zero_error_lock;
        int n;
        do_reset();
        run_to_lock(5, 0, 2000, 1'b0, n);
        n_tests++; if (n !== 399) begin n_fail++; $display("FAIL zero_lock_len: got %0d symbols expected 399", n); end
        n_tests++; if (o_delay !== 4'd5) begin n_fail++; $display("FAIL zero_lock_delay: got %0d expected 5", o_delay); end
        n_tests++; if (o_err_cnt !== 32'd0 || o_bit_cnt !== 32'd0) begin n_fail++; $display("FAIL zero_lock_counts: err=%0d bit=%0d expected 0/0", o_err_cnt, o_bit_cnt); end
    endtask

    task automatic test_error_injection;
        chk_ber = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            sym(5, (k % 10) == 9);
            if ((k % 100) == 49) begin
                idle();
                n_tests++;
                if (o_ber !== last_exp) begin n_fail++; $display("FAIL ber_hold: o_ber=%0b expected %0b", o_ber, last_exp); end
            end
        end
        chk_ber = 1'b0;
        n_tests++; if (o_err_cnt !== 32'd100) begin n_fail++; $display("FAIL inject_err: got %0d expected 100", o_err_cnt); end
        n_tests++; if (o_bit_cnt !== 32'd1000) begin n_fail++; $display("FAIL inject_bit: got %0d expected 1000", o_bit_cnt); end
    endtask

    task automatic test_impaired_lock;
        int n;
        do_reset();
        run_to_lock(3, 8, 2000, 1'b0, n);
        n_tests++; if (n !== 1039) begin n_fail++; $display("FAIL impaired_len: got %0d symbols expected 1039", n); end
        n_tests++; if (o_delay !== 4'd3 || o_locked !== 1'b1) begin n_fail++; $display("FAIL impaired_delay: delay=%0d locked=%0b expected 3/1", o_delay, o_locked); end
        for (int k = 0; k < 800; k++) begin
            sym(3, (inv_ctr % 8) == 7);
            inv_ctr++;
        end
        n_tests++; if (o_bit_cnt !== 32'd800) begin n_fail++; $display("FAIL impaired_bit: got %0d expected 800", o_bit_cnt); end
        n_tests++; if (o_err_cnt !== 32'd100) begin n_fail++; $display("FAIL impaired_err: got %0d expected 100", o_err_cnt); end
    endtask

    task automatic test_enable_gating;
        int n;
        do_reset();
        for (int k = 0; k < 115; k++) sym(5, 1'b0);
        i_enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            i_valid   = 1'b1;
            i_restart = c[0];
            i_prbs    = 1'($urandom);
            i_slicer  = 1'($urandom);
            tick();
            n_tests++;
            if (o_delay !== 4'd1 || o_locked !== 1'b0 || o_bit_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL disabled_hold: delay=%0d locked=%0b bit=%0d expected 1/0/0", o_delay, o_locked, o_bit_cnt);
            end
        end
        i_valid = 1'b0; i_restart = 1'b0; i_enable = 1'b1;
        run_to_lock(5, 0, 2000, 1'b0, n);
        n_tests++; if (n + 115 !== 399 || o_delay !== 4'd5) begin n_fail++; $display("FAIL enable_lock: symbols=%0d delay=%0d expected 399/5", n + 115, o_delay); end
        for (int k = 0; k < 1000; k++) sym(5, (k % 10) == 9);
        n_tests++; if (o_err_cnt !== 32'd100 || o_bit_cnt !== 32'd1000) begin n_fail++; $display("FAIL enable_counts: err=%0d bit=%0d expected 100/1000", o_err_cnt, o_bit_cnt); end
    endtask

    task automatic test_valid_gating;
        int n;
        do_reset();
        run_to_lock(5, 0, 2000, 1'b1, n);
        n_tests++; if (n !== 399 || o_delay !== 4'd5) begin n_fail++; $display("FAIL valid_lock: symbols=%0d delay=%0d expected 399/5", n, o_delay); end
        for (int k = 0; k < 1000; k++) begin
            idle();
            sym(5, (k % 10) == 9);
        end
        n_tests++; if (o_err_cnt !== 32'd100 || o_bit_cnt !== 32'd1000) begin n_fail++; $display("FAIL valid_counts: err=%0d bit=%0d expected 100/1000", o_err_cnt, o_bit_cnt); end
    endtask

    task automatic test_restart;
        int n;
        // Restart coincident with an inverted valid symbol: shifted, not counted.
        i_restart = 1'b1;
        sym(5, 1'b1);
        n_tests++; if (o_locked !== 1'b0 || o_delay !== 4'd0) begin n_fail++; $display("FAIL restart_state: locked=%0b delay=%0d expected 0/0", o_locked, o_delay); end
        n_tests++; if (o_err_cnt !== 32'd0 || o_bit_cnt !== 32'd0 || o_ber !== 1'b0) begin n_fail++; $display("FAIL restart_clear: err=%0d bit=%0d ber=%0b expected 0/0/0", o_err_cnt, o_bit_cnt, o_ber); end
        run_to_lock(5, 0, 2000, 1'b0, n);
        n_tests++; if (n !== 384 || o_delay !== 4'd5) begin n_fail++; $display("FAIL restart_relock: symbols=%0d delay=%0d expected 384/5", n, o_delay); end
    endtask

    task automatic test_midsearch_reset;
        int n;
        do_reset();
        for (int k = 0; k < 215; k++) sym(5, 1'b0);
        n_tests++; if (o_delay !== 4'd3) begin n_fail++; $display("FAIL midsearch_cand: got %0d expected 3", o_delay); end
        // Reset wins even with the block disabled.
        i_enable = 1'b0;
        do_reset();
        i_enable = 1'b1;
        n_tests++; if (o_delay !== 4'd0 || o_locked !== 1'b0 || o_err_cnt !== 32'd0 || o_bit_cnt !== 32'd0 || o_ber !== 1'b0) begin
            n_fail++;
            $display("FAIL midsearch_reset: delay=%0d locked=%0b err=%0d bit=%0d ber=%0b expected all 0", o_delay, o_locked, o_err_cnt, o_bit_cnt, o_ber);
        end
        run_to_lock(5, 0, 2000, 1'b0, n);
        n_tests++; if (n !== 399 || o_delay !== 4'd5) begin n_fail++; $display("FAIL midsearch_relock: symbols=%0d delay=%0d expected 399/5", n, o_delay); end
    endtask

    task automatic test_saturation;
        int n;
        i_restart = 1'b1;
        sym(5, 1'b0);
        run_to_lock(5, 0, 2000, 1'b0, n);
        n_tests++; if (n !== 384 || d8_locked !== 1'b1 || d8_delay !== 4'd5) begin n_fail++; $display("FAIL sat_lock: symbols=%0d locked=%0b delay=%0d expected 384/1/5", n, d8_locked, d8_delay); end
        for (int k = 0; k < 300; k++) begin
            sym(5, 1'b1);
            if (k >= 255) begin
                n_tests++;
                if (d8_ber !== 1'b1 || d8_bit_cnt !== 8'd255 || d8_err_cnt !== 8'd255) begin
                    n_fail++;
                    $display("FAIL sat_frozen: ber=%0b bit=%0d err=%0d expected 1/255/255", d8_ber, d8_bit_cnt, d8_err_cnt);
                end
            end
        end
        n_tests++; if (o_bit_cnt !== 32'd300 || o_err_cnt !== 32'd300) begin n_fail++; $display("FAIL wide_counts: bit=%0d err=%0d expected 300/300", o_bit_cnt, o_err_cnt); end
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0;
        i_prbs = 1'b0; i_slicer = 1'b0; i_restart = 1'b0;
        test_reset();
        test_zero_error_lock();
        test_error_injection();
        test_impaired_lock();
        test_enable_gating();
        test_valid_gating();
        test_restart();
        test_midsearch_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
